// File: rtl/seg_pkg.sv
// Shared constants and digit-slot type for the 7-segment scan controller.
package seg_pkg;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_NINE  = 8'h39;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_CLR_U = 8'h43;
    localparam logic [7:0] ASC_CLR_L = 8'h63;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [3:0] val;
    } seg_slot_t;

    localparam seg_slot_t BLANK_SLOT = '{valid: 1'b0, val: BLANK_CODE};

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Receive strobe/byte in, multiplexed digit bus and status out.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIG = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_DIG);

    logic               rx_valid;
    logic [7:0]         rx_data;
    logic [3:0]         dec_out;
    logic [NUM_DIG-1:0] an;
    logic [IDX_W:0]     digit_cnt;
    logic               bad_char;

    modport master (
        output rx_valid, rx_data,
        input  dec_out, an, digit_cnt, bad_char
    );

    modport slave (
        input  rx_valid, rx_data,
        output dec_out, an, digit_cnt, bad_char
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Scan prescaler: advances the digit index once every SCAN_DIV clocks.
module seg_scan_timer #(
    parameter int unsigned NUM_DIG  = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [$clog2(NUM_DIG)-1:0] o_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_DIG);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

    logic [PRE_W-1:0] r_pre;
    logic [IDX_W-1:0] r_idx;
    logic             w_tick;

    assign w_tick = (r_pre == LAST_PRE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit buffer fed by ASCII commands, time-multiplexed onto one BCD bus.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros on display only.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIG  = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_DIG);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIG);

    seg_slot_t [NUM_DIG-1:0] r_buf;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DIG-1:0]      r_an;
    logic [3:0]              r_dec;
    logic                    r_bad;

    seg_slot_t [NUM_DIG-1:0] w_buf_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_bad_nxt;
    logic [NUM_DIG-1:0]      w_an_nxt;
    logic [3:0]              w_dec_nxt;
    logic [NUM_DIG-1:0]      w_vis;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_is_dig;
    logic [3:0]              w_dig;

    seg_scan_timer #(
        .NUM_DIG  (NUM_DIG),
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .o_idx (w_idx)
    );

    assign w_is_dig = (bus.rx_data >= ASC_ZERO) && (bus.rx_data <= ASC_NINE);
    assign w_dig    = 4'(bus.rx_data - ASC_ZERO);

    // Command decode: next buffer contents, count and bad-character pulse.
    always_comb begin
        w_buf_nxt = r_buf;
        w_cnt_nxt = r_cnt;
        w_bad_nxt = 1'b0;
        if (bus.rx_valid) begin
            if (w_is_dig) begin
                for (int i = NUM_DIG - 1; i > 0; i--) begin
                    w_buf_nxt[i] = r_buf[i-1];
                end
                w_buf_nxt[0] = '{valid: 1'b1, val: w_dig};
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else if (bus.rx_data == ASC_BS) begin
                if (r_cnt != '0) begin
                    for (int i = 0; i < NUM_DIG - 1; i++) begin
                        w_buf_nxt[i] = r_buf[i+1];
                    end
                    w_buf_nxt[NUM_DIG-1] = BLANK_SLOT;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end else if ((bus.rx_data == ASC_CLR_U) || (bus.rx_data == ASC_CLR_L)) begin
                for (int i = 0; i < NUM_DIG; i++) begin
                    w_buf_nxt[i] = BLANK_SLOT;
                end
                w_cnt_nxt = '0;
            end else if ((bus.rx_data == ASC_CR) || (bus.rx_data == ASC_LF)) begin
                w_bad_nxt = 1'b0;
            end else begin
                w_bad_nxt = 1'b1;
            end
        end
    end

    // Per-slot visibility; storage is untouched by zero suppression.
`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic nz_above;
        nz_above = 1'b0;
        w_vis    = '0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            w_vis[i] = r_buf[i].valid &&
                       ((i == 0) || (r_buf[i].val != 4'd0) || nz_above);
            nz_above = nz_above || (r_buf[i].valid && (r_buf[i].val != 4'd0));
        end
    end
`else
    always_comb begin
        w_vis = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            w_vis[i] = r_buf[i].valid;
        end
    end
`endif

    // Display for the current slot, registered at the next edge.
    always_comb begin
        w_an_nxt  = '1;
        w_dec_nxt = BLANK_CODE;
        if (w_vis[w_idx]) begin
            w_an_nxt  = ~(NUM_DIG'(1) << w_idx);
            w_dec_nxt = r_buf[w_idx].val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                r_buf[i] <= BLANK_SLOT;
            end
            r_cnt <= '0;
            r_an  <= '1;
            r_dec <= BLANK_CODE;
            r_bad <= 1'b0;
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_nxt;
            r_an  <= w_an_nxt;
            r_dec <= w_dec_nxt;
            r_bad <= w_bad_nxt;
        end
    end

    assign bus.an        = r_an;
    assign bus.dec_out   = r_dec;
    assign bus.digit_cnt = r_cnt;
    assign bus.bad_char  = r_bad;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIG=4 and a short SCAN_DIV.
module tb_seg_scan_ctrl;

    localparam int unsigned NUM_DIG  = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned PERIOD   = NUM_DIG * SCAN_DIV;

    logic clk;
    logic rst_n;
    int   total;
    int   passes;
    int   fails;

    seg_scan_ctrl_if #(.NUM_DIG(NUM_DIG)) bus_if ();

    seg_scan_ctrl #(
        .NUM_DIG  (NUM_DIG),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    // Observe one full refresh period; ev holds the expected value per slot.
    task automatic scan(input string tag, input logic [15:0] ev, input logic [3:0] on);
        int         cnt [NUM_DIG];
        int         bad;
        logic       found;
        logic [3:0] mask;
        bad = 0;
        for (int k = 0; k < NUM_DIG; k++) cnt[k] = 0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < int'(PERIOD); c++) begin
            @(negedge clk);
            if (bus_if.an == 4'b1111) begin
                if (bus_if.dec_out !== 4'hF) bad++;
            end else begin
                found = 1'b0;
                for (int k = 0; k < NUM_DIG; k++) begin
                    mask = ~(4'b0001 << k);
                    if (bus_if.an == mask) begin
                        found = 1'b1;
                        cnt[k]++;
                        if (bus_if.dec_out !== ev[k*4 +: 4]) bad++;
                    end
                end
                if (!found) bad++;
            end
        end
        for (int k = 0; k < NUM_DIG; k++) begin
            check($sformatf("%s slot%0d lit cycles", tag, k), 32'(cnt[k]),
                  on[k] ? 32'(SCAN_DIV) : 32'd0);
        end
        check({tag, " display errors"}, 32'(bad), 32'd0);
    endtask

    initial begin
        total  = 0;
        passes = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset an", 32'(bus_if.an), 32'hF);
        check("reset dec", 32'(bus_if.dec_out), 32'hF);
        check("reset cnt", 32'(bus_if.digit_cnt), 32'd0);
        check("reset bad", 32'(bus_if.bad_char), 32'd0);
        rst_n = 1'b1;
        scan("idle", 16'hFFFF, 4'b0000);

        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        check("cnt after 1234", 32'(bus_if.digit_cnt), 32'd4);
        scan("1234", 16'h1234, 4'b1111);

        send(8'h35);
        check("cnt saturate", 32'(bus_if.digit_cnt), 32'd4);
        scan("2345", 16'h2345, 4'b1111);

        send(8'h08); send(8'h08);
        check("bs no bad", 32'(bus_if.bad_char), 32'd0);
        check("cnt after bs", 32'(bus_if.digit_cnt), 32'd2);
        scan("23", 16'hFF23, 4'b0011);

        send(8'h41);
        check("bad pulse", 32'(bus_if.bad_char), 32'd1);
        @(negedge clk);
        check("bad pulse end", 32'(bus_if.bad_char), 32'd0);
        check("cnt after A", 32'(bus_if.digit_cnt), 32'd2);
        scan("after A", 16'hFF23, 4'b0011);

        send(8'h0D);
        check("cr silent", 32'(bus_if.bad_char), 32'd0);
        send(8'h0A);
        check("lf silent", 32'(bus_if.bad_char), 32'd0);
        check("cnt after crlf", 32'(bus_if.digit_cnt), 32'd2);

        send(8'h63);
        check("cnt after clr", 32'(bus_if.digit_cnt), 32'd0);
        scan("cleared", 16'hFFFF, 4'b0000);

        send(8'h08);
        check("bs empty no bad", 32'(bus_if.bad_char), 32'd0);
        check("bs empty cnt", 32'(bus_if.digit_cnt), 32'd0);

        send(8'h30); send(8'h30); send(8'h37);
        check("cnt after 007", 32'(bus_if.digit_cnt), 32'd3);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        scan("007", 16'hF007, 4'b0001);
`else
        scan("007", 16'hF007, 4'b0111);
`endif

        // Reset mid-scan with a digit strobe in the same cycle.
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h39;
        @(negedge clk);
        check("midrst an", 32'(bus_if.an), 32'hF);
        check("midrst dec", 32'(bus_if.dec_out), 32'hF);
        check("midrst cnt", 32'(bus_if.digit_cnt), 32'd0);
        check("midrst bad", 32'(bus_if.bad_char), 32'd0);
        rst_n = 1'b1;
        bus_if.rx_data = 8'h38;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        check("post rst latency an", 32'(bus_if.an), 32'hF);
        check("post rst cnt", 32'(bus_if.digit_cnt), 32'd1);
        for (int e = 2; e <= 4; e++) begin
            @(negedge clk);
            check($sformatf("slot0 lit e%0d", e), 32'(bus_if.an), 32'hE);
            check($sformatf("slot0 val e%0d", e), 32'(bus_if.dec_out), 32'h8);
        end
        @(negedge clk);
        check("slot0 off e5", 32'(bus_if.an), 32'hF);
        repeat (11) @(negedge clk);
        check("slot0 off e16", 32'(bus_if.an), 32'hF);
        @(negedge clk);
        check("slot0 relit e17", 32'(bus_if.an), 32'hE);
        scan("after rst", 16'hFFF8, 4'b0001);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Digit-buffer and scan controller between the UART receive path and the 7-segment decoder. Accepts received bytes as ASCII digit and command characters, holds the last NUM_DIG digits, and time-multiplexes them onto one shared 4-bit BCD bus and a one-hot, active-low digit-enable bus. The existing BCD-to-segment decoder consumes dec_out, so one decoder drives all digits.

Parameters:
- NUM_DIG, 4, number of display digits; legal range 2..8.
- SCAN_DIV, 50000, clk cycles per digit slot; minimum 2.
- IDX_W, $clog2(NUM_DIG), scan index width; derived, do not override.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
- rx_data  in  8  received ASCII byte
- dec_out  out  4  BCD value of the digit in the current slot; 4'hF when the digit is blank
- an  out  NUM_DIG  digit enables, active low, at most one bit low
- digit_cnt  out  IDX_W+1  number of valid digits held, 0..NUM_DIG
- bad_char  out  1  one-cycle pulse when an unrecognised byte is dropped

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All buffer slots are blank. digit_cnt=0, scan idx=0, prescaler=0.
  - an = all ones. dec_out = 4'hF. bad_char = 0.
  - Reset wins over every other event in the same cycle, including reset asserted mid-scan or on an rx_valid cycle.
- Buffer: slot d[0] is the rightmost digit. Each slot holds a 4-bit value plus a valid bit.
- Command decode, applied only in cycles with rx_valid=1. The buffer updates at the next edge.
  - 0x30..0x39 ('0'..'9'): shift left (d[i] <= d[i-1]), d[0] <= rx_data-0x30 marked valid. The old d[NUM_DIG-1] is discarded. digit_cnt increments and saturates at NUM_DIG.
  - 0x08 (backspace): shift right (d[i] <= d[i+1]), top slot becomes blank. digit_cnt decrements. When digit_cnt=0 the command is a no-op and bad_char is not pulsed.
  - 0x43 / 0x63 ('C'/'c'): all slots blank, digit_cnt=0.
  - 0x0D, 0x0A: ignored silently.
  - Any other value: buffer unchanged, bad_char=1 for exactly the next cycle.
- Scan timing:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - The cycle with prescaler=SCAN_DIV-1 is the tick. On a tick, idx <= (idx==NUM_DIG-1) ? 0 : idx+1.
  - The full refresh period is NUM_DIG*SCAN_DIV cycles.
- Outputs are registered and computed from the idx and buffer values of the previous cycle (one-cycle latency).
  - Slot valid: an bit idx = 0, all other bits = 1; dec_out = d[idx].
  - Slot blank: an = all ones; dec_out = 4'hF.
- Simultaneous events:
  - An rx_valid arriving in the same cycle as a tick is processed.
  - Both the buffer and idx advance at the same edge.
  - The new content appears on the outputs one cycle later.
  - No byte is ever lost. rx_valid may be high on consecutive cycles.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: a valid '0' digit in any slot above the highest non-zero valid digit is displayed as blank (an all ones, dec_out=4'hF). Slot d[0] is never suppressed. Storage and digit_cnt are unaffected.
- Not defined: every valid digit is displayed, including leading zeros.

Decomposition:
- Shared package seg_pkg holds:
  - ASCII constants: ASC_ZERO=8'h30, ASC_NINE=8'h39, ASC_BS=8'h08, ASC_CLR_U=8'h43, ASC_CLR_L=8'h63, ASC_CR=8'h0D, ASC_LF=8'h0A.
  - BLANK_CODE=4'hF.
  - The digit-slot typedef (4-bit value plus valid bit).
- One sub-module, seg_scan_timer, contains the prescaler, the tick, and the idx wrap logic.
- Buffer and command decode stay in the top module.

Test Plan:
- Reset, then idle 4*SCAN_DIV cycles -> an=4'b1111 throughout, dec_out=4'hF, digit_cnt=0.
- Send '1','2','3','4' -> digit_cnt=4; over one refresh period dec_out shows 4,3,2,1 on an=1110,1101,1011,0111 respectively.
- Send '5' with the buffer full -> the buffer reads 2,3,4,5 (d3..d0) and digit_cnt stays 4.
- Send 0x08 twice, then 'c' -> after the backspaces only an=1110/1101 go low with values 3/2; after 'c', an=1111 and digit_cnt=0.
- Send 0x41 ('A') -> bad_char is high for exactly one cycle and the buffer is unchanged.
- Send '0','0','7' with SEG_LEADING_ZERO_BLANK_EN -> only the slot-0 enable goes low (dec_out=7). Without the macro, slots 0..2 light with values 7,0,0.
- Assert rst_n=0 for 1 cycle mid-scan, coincident with rx_valid='9' -> all state is cleared and '9' is not stored.
